// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two asynchronous read ports, an optional
// hardwired zero register, an optional write-to-read bypass, a multi-cycle soft-clear
// sweep and a registered debug read port.
module regfile_param #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 5,
  parameter bit                ZERO_REG = 1'b1,
  parameter bit                BYPASS   = 1'b1,
  parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
  input  logic              clka,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              reg_write,
  input  logic              clr,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] ans
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // One extra bit so the final sweep address is unambiguous.
  localparam logic [ADDR_W:0] PtrLast = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic {StIdle, StSweep} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] ans_q, ans_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] mem_d [Depth];

  logic [ADDR_W-1:0] ptr_idx;
  logic              bypass_en;

  assign ptr_idx   = ptr_q[ADDR_W-1:0];
  assign bypass_en = BYPASS && (state_q == StIdle) && reg_write;
  assign busy      = busy_q;
  assign ans       = ans_q;

  // Next-state: writes in idle, one entry cleared per cycle while sweeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    unique case (state_q)
      StIdle: begin
        if (reg_write && !(ZERO_REG && (WriteAddr == '0))) begin
          mem_d[WriteAddr] = WriteData;
        end
        // A same-cycle write still lands; the sweep will overwrite it later.
        if (clr) begin
          state_d = StSweep;
          ptr_d   = '0;
        end
      end
      StSweep: begin
        mem_d[ptr_idx] = (ZERO_REG && (ptr_idx == '0)) ? '0 : RST_VAL;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == PtrLast) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StSweep);
    ans_d  = (ZERO_REG && (dbg_addr == '0)) ? '0 : mem_q[dbg_addr];
  end

  // State, storage and debug register with synchronous reset.
  always_ff @(posedge clka) begin
    if (rst) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RST_VAL;
      end
      state_q <= StIdle;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
      ans_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      ans_q   <= ans_d;
    end
  end

  // Read port 1: zero register first, then bypass, then stored value.
  always_comb begin
    ReadData1 = mem_q[ReadAddr1];
    if (bypass_en && (ReadAddr1 == WriteAddr)) begin
      ReadData1 = WriteData;
    end
    if (ZERO_REG && (ReadAddr1 == '0)) begin
      ReadData1 = '0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    ReadData2 = mem_q[ReadAddr2];
    if (bypass_en && (ReadAddr2 == WriteAddr)) begin
      ReadData2 = WriteData;
    end
    if (ZERO_REG && (ReadAddr2 == '0)) begin
      ReadData2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations share one stimulus stream; a behavioural
// model per configuration pushes expected outputs into a scoreboard queue.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, we = 1'b0, clr = 1'b0;
  logic [4:0]  ra1 = '0, ra2 = '0, wa = '0, dbg = '0;
  logic [31:0] wd = '0;

  logic [31:0] a_rd1, a_rd2, a_ans, c_rd1, c_rd2, c_ans;
  logic [15:0] b_rd1, b_rd2, b_ans;
  logic        a_busy, b_busy, c_busy;

  // A: defaults. C: no zero register, no bypass. B: small, RST_VAL 00FF, no bypass.
  regfile_param dut_a (
    .clka(clk), .rst(rst), .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(a_rd1),
    .ReadData2(a_rd2), .WriteAddr(wa), .WriteData(wd), .reg_write(we), .clr(clr),
    .busy(a_busy), .dbg_addr(dbg), .ans(a_ans)
  );

  regfile_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_c (
    .clka(clk), .rst(rst), .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(c_rd1),
    .ReadData2(c_rd2), .WriteAddr(wa), .WriteData(wd), .reg_write(we), .clr(clr),
    .busy(c_busy), .dbg_addr(dbg), .ans(c_ans)
  );

  regfile_param #(
    .DATA_W(16), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b0), .RST_VAL(16'h00FF)
  ) dut_b (
    .clka(clk), .rst(rst), .ReadAddr1(ra1[2:0]), .ReadAddr2(ra2[2:0]), .ReadData1(b_rd1),
    .ReadData2(b_rd2), .WriteAddr(wa[2:0]), .WriteData(wd[15:0]), .reg_write(we),
    .clr(clr), .busy(b_busy), .dbg_addr(dbg[2:0]), .ans(b_ans)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   en = 1'b0;

  // Model configuration, index 0 = A, 1 = C, 2 = B.
  string       nm    [3] = '{"A", "C", "B"};
  int          aw    [3] = '{5, 5, 3};
  bit          zr    [3] = '{1'b1, 1'b0, 1'b1};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b0};
  logic [31:0] rv    [3] = '{32'h0, 32'h0, 32'h0000_00FF};
  logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};

  logic [31:0] mm [3][32];
  bit          mbusy [3];
  int          mptr [3];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return a_rd1;
      1:       return a_rd2;
      2:       return {31'b0, a_busy};
      3:       return a_ans;
      4:       return c_rd1;
      5:       return c_rd2;
      6:       return {31'b0, c_busy};
      7:       return c_ans;
      8:       return {16'b0, b_rd1};
      9:       return {16'b0, b_rd2};
      10:      return {31'b0, b_busy};
      default: return {16'b0, b_ans};
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input int m, input logic [4:0] a_in);
    int a, w;
    a = int'(a_in) & ((1 << aw[m]) - 1);
    w = int'(wa) & ((1 << aw[m]) - 1);
    if (zr[m] && a == 0) return 32'h0;
    if (byp[m] && !mbusy[m] && we && a == w) return wd & dmask[m];
    return mm[m][a];
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp, input int due);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic model_edge();
    for (int m = 0; m < 3; m++) begin
      int n, w, d;
      n = 1 << aw[m];
      w = int'(wa) & (n - 1);
      d = int'(dbg) & (n - 1);
      if (rst) begin
        for (int i = 0; i < n; i++) mm[m][i] = (zr[m] && i == 0) ? 32'h0 : rv[m];
        mbusy[m] = 1'b0;
        mptr[m]  = 0;
      end else if (mbusy[m]) begin
        mm[m][mptr[m]] = (zr[m] && mptr[m] == 0) ? 32'h0 : rv[m];
        mptr[m]++;
        if (mptr[m] == n) mbusy[m] = 1'b0;
      end else begin
        if (we && !(zr[m] && w == 0)) mm[m][w] = wd & dmask[m];
        if (clr) begin
          mbusy[m] = 1'b1;
          mptr[m]  = 0;
        end
      end
    end
  endtask

  // One clock: predict, compare at negedge, advance the model at posedge.
  task automatic tick();
    exp_t keep[$];
    for (int m = 0; m < 3; m++) begin
      int d;
      logic [31:0] ans_exp;
      d = int'(dbg) & ((1 << aw[m]) - 1);
      if (en) begin
        push($sformatf("%s rd1 a%0d", nm[m], ra1), m * 4 + 0, exp_read(m, ra1), cyc);
        push($sformatf("%s rd2 a%0d", nm[m], ra2), m * 4 + 1, exp_read(m, ra2), cyc);
        push($sformatf("%s busy", nm[m]), m * 4 + 2, {31'b0, mbusy[m]}, cyc);
      end
      ans_exp = (rst || (zr[m] && d == 0)) ? 32'h0 : mm[m][d];
      push($sformatf("%s ans a%0d", nm[m], d), m * 4 + 3, ans_exp, cyc + 1);
    end
    @(negedge clk);
    foreach (sb[i]) begin
      if (sb[i].due == cyc) check_eq(sb[i].tag, observe(sb[i].sel), sb[i].exp);
      else keep.push_back(sb[i]);
    end
    sb = keep;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  initial begin
    int busy_cnt;
    rst = 1'b1;
    tick();
    en = 1'b1;
    tick();
    rst = 1'b0;

    // Post-reset contents and debug port.
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      dbg = 5'(i);
      tick();
    end

    // Bypass on A; C and B show the stored value until the next cycle.
    wa = 5'd1; wd = 32'hAAAA_AAAA; we = 1'b1; ra1 = 5'd1; ra2 = 5'd1; dbg = 5'd1;
    tick();
    we = 1'b0;
    tick();

    // Writes to register 0: dropped on A/B, kept on C.
    wa = 5'd0; wd = 32'hDEAD_BEEF; we = 1'b1; ra1 = 5'd0; dbg = 5'd0;
    tick();
    we = 1'b0;
    tick();

    // Load every register with its index.
    for (int i = 1; i < 32; i++) begin
      wa = 5'(i); wd = 32'(i); we = 1'b1; ra1 = 5'(i); ra2 = 5'(i - 1); dbg = 5'(i - 1);
      tick();
    end
    we = 1'b0;

    // Sweep: mid-sweep write and second clr must both be ignored by A.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_busy) busy_cnt++;
      ra1 = 5'd7; ra2 = 5'(k % 32); dbg = 5'(k % 32);
      we  = (k == 5);
      wa  = 5'd7; wd = 32'h5;
      clr = (k == 10);
      tick();
    end
    we = 1'b0; clr = 1'b0;
    check_eq("A busy cycles", 32'(busy_cnt), 32'd32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i); dbg = 5'(i);
      tick();
    end

    // Reset aborts a sweep; a write right after must succeed.
    for (int i = 1; i < 5; i++) begin
      wa = 5'(i); wd = 32'(i * 3); we = 1'b1;
      tick();
    end
    we = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wa = 5'd3; wd = 32'h0000_1234; we = 1'b1; ra1 = 5'd3; ra2 = 5'd2; dbg = 5'd3;
    tick();
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 5'(i); ra2 = 5'(i + 8); dbg = 5'(i);
      tick();
    end

    // Random traffic with occasional clr and reset.
    repeat (300) begin
      ra1 = 5'($urandom); ra2 = 5'($urandom); wa = 5'($urandom); dbg = 5'($urandom);
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; we = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
